// File: rtl/div_arb_seq.sv
// -----------------------------------------------------------------------------
// div_arb_seq
// Shared iterative unsigned divider with a two-requester round-robin front end.
// One requester is granted at a time. Its operands are captured, and a restoring
// radix-2 division produces one quotient bit per clock. When the division ends,
// the quotient, remainder and divide-by-zero flag are returned, tagged with the
// ID of the requester that owns them.
//
// Ports:
//   CLK           rising-edge clock
//   RST           synchronous reset, active-high
//   REQ0/DVD0/DSR0  requester 0 request, dividend, divisor
//   REQ1/DVD1/DSR1  requester 1 request, dividend, divisor
//   GNT0/GNT1     one-cycle pulse: that requester's operands were captured
//   BUSY          high while a division iterates
//   DONE          one-cycle pulse: Q/R/DZ/DONE_ID carry a new result
//   DONE_ID       requester that owns the current result
//   Q/R           quotient / remainder, held until the next DONE
//   DZ            divide-by-zero flag, held until the next DONE
// -----------------------------------------------------------------------------
module div_arb_seq #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         REQ0,
   input  logic [W-1:0] DVD0,
   input  logic [W-1:0] DSR0,
   input  logic         REQ1,
   input  logic [W-1:0] DVD1,
   input  logic [W-1:0] DSR1,
   output logic         GNT0,
   output logic         GNT1,
   output logic         BUSY,
   output logic         DONE,
   output logic         DONE_ID,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         DZ
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic            last_q, last_d;
   logic            id_q, id_d;
   logic [W-1:0]    dsr_q, dsr_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    qsh_q, qsh_d;
   logic [CW-1:0]   count_q, count_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            done_id_q, done_id_d;
   logic [W-1:0]    q_q, q_d;
   logic [W-1:0]    r_q, r_d;
   logic            dz_q, dz_d;

   logic            winner_s;
   logic [W-1:0]    sel_dvd_s;
   logic [W-1:0]    sel_dsr_s;
   logic [W:0]      step_s;

   // One restoring step: returns {next remainder, quotient bit}.
   // The subtraction runs at W+2 bits so its top bit is a clean borrow.
   function automatic logic [W:0] div_step(input logic [W-1:0] rem,
                                           input logic [W-1:0] qsh,
                                           input logic [W-1:0] dsr);
      logic [W:0]   t;
      logic [W+1:0] d;
      logic         borrow;
      t      = {rem, qsh[W-1]};
      d      = {1'b0, t} - {2'b00, dsr};
      borrow = d[W+1];
      div_step = borrow ? {t[W-1:0], 1'b0} : {d[W-1:0], 1'b1};
   endfunction

   // Arbitration: a lone requester wins; on a tie the one not granted last wins.
   always_comb begin
      winner_s  = 1'b0;
      sel_dvd_s = {W{1'b0}};
      sel_dsr_s = {W{1'b0}};
      if (REQ0 && REQ1) begin
         winner_s = ~last_q;
      end else begin
         winner_s = REQ1;
      end
      if (winner_s) begin
         sel_dvd_s = DVD1;
         sel_dsr_s = DSR1;
      end else begin
         sel_dvd_s = DVD0;
         sel_dsr_s = DSR0;
      end
   end

   // Datapath step for the current iteration.
   always_comb begin
      step_s = div_step(rem_q, qsh_q, dsr_q);
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      id_d      = id_q;
      dsr_d     = dsr_q;
      rem_d     = rem_q;
      qsh_d     = qsh_q;
      count_d   = count_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      q_d       = q_q;
      r_d       = r_q;
      dz_d      = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (REQ0 || REQ1) begin
               last_d = winner_s;
               id_d   = winner_s;
               gnt0_d = ~winner_s;
               gnt1_d = winner_s;
               dsr_d  = sel_dsr_s;
               if (sel_dsr_s == {W{1'b0}}) begin
                  // Divide by zero completes immediately without iterating.
                  q_d       = {W{1'b1}};
                  r_d       = sel_dvd_s;
                  dz_d      = 1'b1;
                  done_d    = 1'b1;
                  done_id_d = winner_s;
               end else begin
                  rem_d   = {W{1'b0}};
                  qsh_d   = sel_dvd_s;
                  count_d = {CW{1'b0}};
                  busy_d  = 1'b1;
                  state_d = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            rem_d   = step_s[W:1];
            qsh_d   = {qsh_q[W-2:0], step_s[0]};
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            if (count_q == CW'(W - 1)) begin
               q_d       = {qsh_q[W-2:0], step_s[0]};
               r_d       = step_s[W:1];
               dz_d      = 1'b0;
               done_d    = 1'b1;
               done_id_d = id_q;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_CALC;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         last_q    <= 1'b1;
         id_q      <= 1'b0;
         dsr_q     <= {W{1'b0}};
         rem_q     <= {W{1'b0}};
         qsh_q     <= {W{1'b0}};
         count_q   <= {CW{1'b0}};
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         q_q       <= {W{1'b0}};
         r_q       <= {W{1'b0}};
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         id_q      <= id_d;
         dsr_q     <= dsr_d;
         rem_q     <= rem_d;
         qsh_q     <= qsh_d;
         count_q   <= count_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         q_q       <= q_d;
         r_q       <= r_d;
         dz_q      <= dz_d;
      end
   end

   assign GNT0    = gnt0_q;
   assign GNT1    = gnt1_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign DONE_ID = done_id_q;
   assign Q       = q_q;
   assign R       = r_q;
   assign DZ      = dz_q;

endmodule
